// File: rtl/tug_pkg.sv
// Shared definitions for the tug-of-war game state: score widths, default rope positions and FSM states.
package tug_pkg;

    localparam int unsigned SCORE_W         = 5;
    localparam int unsigned CALC_W          = 6;
    localparam int unsigned HOLD_W          = 8;
    localparam int unsigned DEF_START_SCORE = 10;
    localparam int unsigned DEF_MAX_SCORE   = 20;
    localparam int unsigned DEF_HOLD_FRAMES = 120;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        HOLD = 2'd2
    } tug_state_e;

    // One saturating step of the rope position toward the right (up) or left (down) end.
    function automatic logic [CALC_W-1:0] sat_step(
        input logic [CALC_W-1:0] cur,
        input logic              up,
        input logic [CALC_W-1:0] max_val
    );
        logic [CALC_W-1:0] res;
        if (up) begin
            res = (cur >= max_val) ? max_val : cur + CALC_W'(1);
        end else begin
            res = (cur == '0) ? '0 : cur - CALC_W'(1);
        end
        return res;
    endfunction

endpackage

// File: rtl/edge_pulse.sv
// Registered rising-edge detector: one-cycle pulse the cycle after a level is first sampled high.
module edge_pulse (
    input  logic clk,
    input  logic rst_n,
    input  logic i_level,
    output logic o_pulse
);

    logic r_prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prev  <= 1'b0;
            o_pulse <= 1'b0;
        end else begin
            r_prev  <= i_level;
            o_pulse <= i_level & ~r_prev;
        end
    end

endmodule

// File: rtl/tug_score_keeper.sv
// Tug-of-war game state: turns player point edges into a saturating rope position,
// detects wins, holds the final position, and publishes the score only on frame ticks.
module tug_score_keeper
    import tug_pkg::*;
#(
    parameter int unsigned START_SCORE = DEF_START_SCORE,
    parameter int unsigned MAX_SCORE   = DEF_MAX_SCORE,
    parameter int unsigned HOLD_FRAMES = DEF_HOLD_FRAMES
) (
    input  logic               pixelClk,
    input  logic               resetN,
    input  logic               leftPoint,
    input  logic               rightPoint,
    input  logic               frameTick,
    input  logic               startGame,
    output logic [SCORE_W-1:0] score,
    output logic               gameOver,
    output logic               winnerRight,
    output logic               scoreChanged
);

    localparam logic [SCORE_W-1:0] START_VAL = SCORE_W'(START_SCORE);
    localparam logic [CALC_W-1:0]  MAX_CALC  = CALC_W'(MAX_SCORE);
    localparam logic [HOLD_W-1:0]  HOLD_LAST = HOLD_W'(HOLD_FRAMES - 1);

    tug_state_e         r_state;
    tug_state_e         w_state_nxt;
    logic [SCORE_W-1:0] r_live;
    logic [SCORE_W-1:0] w_live_nxt;
    logic [HOLD_W-1:0]  r_hold_cnt;
    logic [HOLD_W-1:0]  w_hold_nxt;
    logic [CALC_W-1:0]  w_step;
    logic [SCORE_W-1:0] w_score_nxt;
    logic               w_changed_nxt;
    logic               w_game_over_nxt;
    logic               w_winner_nxt;
    logic               w_l_edge;
    logic               w_r_edge;

    edge_pulse u_left_edge (
        .clk     (pixelClk),
        .rst_n   (resetN),
        .i_level (leftPoint),
        .o_pulse (w_l_edge)
    );

    edge_pulse u_right_edge (
        .clk     (pixelClk),
        .rst_n   (resetN),
        .i_level (rightPoint),
        .o_pulse (w_r_edge)
    );

    // Candidate position if exactly one player scored this cycle.
    assign w_step = sat_step({1'b0, r_live}, w_r_edge, MAX_CALC);

    always_comb begin
        w_state_nxt   = r_state;
        w_live_nxt    = r_live;
        w_hold_nxt    = r_hold_cnt;
        w_winner_nxt  = winnerRight;
        w_score_nxt   = score;
        w_changed_nxt = 1'b0;

        unique case (r_state)
            IDLE: begin
                if (startGame) begin
                    w_state_nxt = PLAY;
                end
            end
            PLAY: begin
                if (w_l_edge ^ w_r_edge) begin
                    w_live_nxt = SCORE_W'(w_step);
                    if ((w_step == '0) || (w_step == MAX_CALC)) begin
                        w_state_nxt  = HOLD;
                        w_winner_nxt = (w_step == MAX_CALC);
                    end
                end
            end
            HOLD: begin
                if (frameTick) begin
                    if (r_hold_cnt == HOLD_LAST) begin
                        w_state_nxt = IDLE;
                        w_live_nxt  = START_VAL;
                        w_hold_nxt  = '0;
                    end else begin
                        w_hold_nxt = r_hold_cnt + HOLD_W'(1);
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase

        // Publish the pre-update position so an edge coinciding with a tick lands on the next frame.
        if (frameTick) begin
            w_score_nxt   = r_live;
            w_changed_nxt = (r_live != score);
        end

        w_game_over_nxt = (w_state_nxt == HOLD);
    end

    always_ff @(posedge pixelClk or negedge resetN) begin
        if (!resetN) begin
            r_state      <= IDLE;
            r_live       <= START_VAL;
            r_hold_cnt   <= '0;
            score        <= START_VAL;
            scoreChanged <= 1'b0;
            gameOver     <= 1'b0;
            winnerRight  <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_live       <= w_live_nxt;
            r_hold_cnt   <= w_hold_nxt;
            score        <= w_score_nxt;
            scoreChanged <= w_changed_nxt;
            gameOver     <= w_game_over_nxt;
            winnerRight  <= w_winner_nxt;
        end
    end

endmodule

// File: tb/tb_tug_score_keeper.sv
// Scoreboard bench for tug_score_keeper: each frame tick pushes the expected published state.
module tb_tug_score_keeper;

    typedef struct packed {
        logic [4:0] score;
        logic       chg;
        logic       go;
        logic       win;
    } exp_t;

    logic       pixelClk;
    logic       resetN;
    logic       leftPoint;
    logic       rightPoint;
    logic       frameTick;
    logic       startGame;
    logic [4:0] score;
    logic       gameOver;
    logic       winnerRight;
    logic       scoreChanged;

    logic       tick_seen;
    exp_t       exp_q[$];
    int         checks = 0;
    int         errors = 0;

    tug_score_keeper dut (
        .pixelClk     (pixelClk),
        .resetN       (resetN),
        .leftPoint    (leftPoint),
        .rightPoint   (rightPoint),
        .frameTick    (frameTick),
        .startGame    (startGame),
        .score        (score),
        .gameOver     (gameOver),
        .winnerRight  (winnerRight),
        .scoreChanged (scoreChanged)
    );

    initial pixelClk = 1'b0;
    always #5 pixelClk = ~pixelClk;

    always @(posedge pixelClk or negedge resetN) begin
        if (!resetN) tick_seen <= 1'b0;
        else         tick_seen <= frameTick;
    end

    // Monitor: a tick updates the published outputs; any other cycle must not pulse scoreChanged.
    always @(negedge pixelClk) begin
        exp_t e;
        exp_t a;
        if (tick_seen) begin
            checks++;
            a = {score, scoreChanged, gameOver, winnerRight};
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL tick_unexpected: got score=%0d chg=%0d go=%0d win=%0d with empty queue",
                         a.score, a.chg, a.go, a.win);
            end else begin
                e = exp_q.pop_front();
                if (a !== e) begin
                    errors++;
                    $display("FAIL tick_publish @%0t: got score=%0d chg=%0d go=%0d win=%0d, want score=%0d chg=%0d go=%0d win=%0d",
                             $time, a.score, a.chg, a.go, a.win, e.score, e.chg, e.go, e.win);
                end
            end
        end else if (resetN === 1'b1) begin
            checks++;
            if (scoreChanged !== 1'b0) begin
                errors++;
                $display("FAIL idle_chg @%0t: scoreChanged=%0d want 0", $time, scoreChanged);
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge pixelClk);
            #1;
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic pulse(input logic l, input logic r);
        leftPoint  = l;
        rightPoint = r;
        cyc(1);
        leftPoint  = 1'b0;
        rightPoint = 1'b0;
        cyc(3);
    endtask

    task automatic start();
        startGame = 1'b1;
        cyc(1);
        startGame = 1'b0;
        cyc(1);
    endtask

    task automatic tick(input int s, input logic c, input logic g, input logic w);
        exp_t e;
        e.score = 5'(s);
        e.chg   = c;
        e.go    = g;
        e.win   = w;
        exp_q.push_back(e);
        frameTick = 1'b1;
        cyc(1);
        frameTick = 1'b0;
        cyc(1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        exp_t e;
        resetN     = 1'b0;
        leftPoint  = 1'b0;
        rightPoint = 1'b0;
        frameTick  = 1'b0;
        startGame  = 1'b0;
        cyc(3);
        chk("reset_score", int'(score), 10);
        chk("reset_go", int'(gameOver), 0);
        chk("reset_win", int'(winnerRight), 0);
        chk("reset_chg", int'(scoreChanged), 0);
        resetN = 1'b1;
        cyc(2);

        // Edges in IDLE do nothing
        pulse(1'b0, 1'b1);
        pulse(1'b1, 1'b0);
        pulse(1'b0, 1'b1);
        tick(10, 1'b0, 1'b0, 1'b0);

        start();
        repeat (3) pulse(1'b0, 1'b1);
        tick(13, 1'b1, 1'b0, 1'b0);
        tick(13, 1'b0, 1'b0, 1'b0);

        // startGame in PLAY is ignored
        start();
        tick(13, 1'b0, 1'b0, 1'b0);

        repeat (3) pulse(1'b1, 1'b0);
        tick(10, 1'b1, 1'b0, 1'b0);

        // Simultaneous edges cancel
        pulse(1'b1, 1'b1);
        tick(10, 1'b0, 1'b0, 1'b0);

        // rEdge coincides with frameTick: old value published now, new value next tick
        rightPoint = 1'b1;
        cyc(1);
        e = '{score: 5'd10, chg: 1'b0, go: 1'b0, win: 1'b0};
        exp_q.push_back(e);
        frameTick  = 1'b1;
        rightPoint = 1'b0;
        cyc(1);
        frameTick = 1'b0;
        cyc(2);
        tick(11, 1'b1, 1'b0, 1'b0);

        pulse(1'b1, 1'b0);
        tick(10, 1'b1, 1'b0, 1'b0);

        // Left win, extra point ignored, hold for 120 ticks then re-centre
        repeat (10) pulse(1'b1, 1'b0);
        chk("left_win_go", int'(gameOver), 1);
        chk("left_win_who", int'(winnerRight), 0);
        tick(0, 1'b1, 1'b1, 1'b0);
        pulse(1'b1, 1'b0);
        for (int i = 2; i <= 119; i++) tick(0, 1'b0, 1'b1, 1'b0);
        tick(0, 1'b0, 1'b0, 1'b0);
        tick(10, 1'b1, 1'b0, 1'b0);
        pulse(1'b0, 1'b1);
        tick(10, 1'b0, 1'b0, 1'b0);

        // Right win, then async reset at hold frame 50
        start();
        repeat (10) pulse(1'b0, 1'b1);
        chk("right_win_go", int'(gameOver), 1);
        chk("right_win_who", int'(winnerRight), 1);
        tick(20, 1'b1, 1'b1, 1'b1);
        for (int i = 2; i <= 50; i++) tick(20, 1'b0, 1'b1, 1'b1);
        resetN = 1'b0;
        #2;
        chk("midreset_score", int'(score), 10);
        chk("midreset_go", int'(gameOver), 0);
        chk("midreset_win", int'(winnerRight), 0);
        chk("midreset_chg", int'(scoreChanged), 0);
        cyc(2);
        resetN = 1'b1;
        cyc(2);

        pulse(1'b0, 1'b1);
        tick(10, 1'b0, 1'b0, 1'b0);
        start();
        pulse(1'b0, 1'b1);
        tick(11, 1'b1, 1'b0, 1'b0);

        cyc(3);
        chk("queue_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
